// File: rtl/hazard_fwd_ctrl.sv
// Hazard detection and operand-forwarding control for a 5-stage pipeline.
// Produces stall/bubble/freeze controls, registered forward selects and a stall counter.
module hazard_fwd_ctrl #(
  parameter int RW      = 4,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   fwd_en,
  input  logic [NUM_SRC*RW-1:0]  id_src,
  input  logic [NUM_SRC-1:0]     id_src_vld,
  input  logic [RW-1:0]          ex_dest,
  input  logic                   ex_wb_en,
  input  logic                   ex_mem_r_en,
  input  logic [RW-1:0]          mem_dest,
  input  logic                   mem_wb_en,
  input  logic                   mem_busy,
  input  logic                   flush,
  output logic                   stall_front,
  output logic                   bubble,
  output logic                   freeze,
  output logic [2*NUM_SRC-1:0]   fwd_sel,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef enum logic {RUN, MEM_WAIT} state_e;

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_MEM = 2'b01;
  localparam logic [1:0] SEL_WB  = 2'b10;

  state_e                 state_q, state_d;
  logic [2*NUM_SRC-1:0]   fwd_sel_q, fwd_sel_d;
  logic [CNT_W-1:0]       stall_cnt_q, stall_cnt_d;

  logic [NUM_SRC-1:0]     ex_match, mem_match;
  logic [2*NUM_SRC-1:0]   sel_nxt;
  logic                   hz;

  // NOTE: every signal driven in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    ex_match  = '0;
    mem_match = '0;
    sel_nxt   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      ex_match[i]  = id_src_vld[i] & ex_wb_en  & (id_src[i*RW +: RW] == ex_dest);
      mem_match[i] = id_src_vld[i] & mem_wb_en & (id_src[i*RW +: RW] == mem_dest);
      // EX holds the youngest producer, so it wins over MEM.
      if (ex_match[i])       sel_nxt[2*i +: 2] = SEL_MEM;
      else if (mem_match[i]) sel_nxt[2*i +: 2] = SEL_WB;
      else                   sel_nxt[2*i +: 2] = SEL_RF;
    end
  end

  // With forwarding only a load in EX cannot be bypassed; without it any pending write stalls.
  assign hz = fwd_en ? (ex_mem_r_en & (|ex_match)) : (|(ex_match | mem_match));

  // The MEM_WAIT state adds one settle cycle after the memory finishes.
  assign freeze      = mem_busy | (state_q == MEM_WAIT);
  assign stall_front = freeze | (~flush & hz);
  assign bubble      = ~freeze & ~flush & hz;

  always_comb begin
    state_d     = state_q;
    fwd_sel_d   = fwd_sel_q;
    stall_cnt_d = stall_cnt_q;

    unique case (state_q)
      RUN:      if (mem_busy)  state_d = MEM_WAIT;
      MEM_WAIT: if (!mem_busy) state_d = RUN;
      default:                 state_d = RUN;
    endcase

    if (!freeze) begin
      if (flush || hz) fwd_sel_d = '0;
      else             fwd_sel_d = fwd_en ? sel_nxt : '0;
    end

    if (stall_front && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // NOTE: sequential state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= RUN;
      fwd_sel_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      fwd_sel_q   <= fwd_sel_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_sel   = fwd_sel_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: the driver pushes hand-computed expectations,
// a monitor pops and compares them on the falling edge of each cycle.
module tb_hazard_fwd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       fwd_en;
  logic [7:0] id_src;
  logic [1:0] id_src_vld;
  logic [3:0] ex_dest;
  logic       ex_wb_en;
  logic       ex_mem_r_en;
  logic [3:0] mem_dest;
  logic       mem_wb_en;
  logic       mem_busy;
  logic       flush;

  logic        stall_front, bubble, freeze;
  logic [3:0]  fwd_sel;
  logic [15:0] stall_cnt;

  logic        s_stall_front, s_bubble, s_freeze;
  logic [3:0]  s_fwd_sel;
  logic [2:0]  s_stall_cnt;

  hazard_fwd_ctrl #(.RW(4), .NUM_SRC(2), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .id_src(id_src), .id_src_vld(id_src_vld),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_busy(mem_busy), .flush(flush),
    .stall_front(stall_front), .bubble(bubble), .freeze(freeze),
    .fwd_sel(fwd_sel), .stall_cnt(stall_cnt)
  );

  // Narrow counter copy sharing the same stimulus, used to observe saturation.
  hazard_fwd_ctrl #(.RW(4), .NUM_SRC(2), .CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .id_src(id_src), .id_src_vld(id_src_vld),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_busy(mem_busy), .flush(flush),
    .stall_front(s_stall_front), .bubble(s_bubble), .freeze(s_freeze),
    .fwd_sel(s_fwd_sel), .stall_cnt(s_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int          tag;
    logic        sf;
    logic        bub;
    logic        frz;
    logic [3:0]  sel;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_push   = 0;
  int   n_pop    = 0;
  int   cyc_tag  = 0;

  task automatic check(input string name, input int tag, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL c%0d.%s: got %0h, expected %0h", tag, name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc_tag++;
  endtask

  task automatic drv(input logic fe, input logic [3:0] s0, input logic [3:0] s1, input logic [1:0] vld,
                     input logic [3:0] exd, input logic exwb, input logic exld,
                     input logic [3:0] memd, input logic memwb, input logic busy, input logic fl);
    fwd_en = fe; id_src = {s1, s0}; id_src_vld = vld;
    ex_dest = exd; ex_wb_en = exwb; ex_mem_r_en = exld;
    mem_dest = memd; mem_wb_en = memwb; mem_busy = busy; flush = fl;
  endtask

  task automatic expect_out(input logic sf, input logic bub, input logic frz,
                            input logic [3:0] sel, input logic [15:0] cnt);
    exp_t e;
    e.tag = cyc_tag; e.sf = sf; e.bub = bub; e.frz = frz; e.sel = sel; e.cnt = cnt;
    sb.push_back(e);
    n_push++;
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    logic [2:0] cnt3;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_pop++;
        cnt3 = (e.cnt > 16'd7) ? 3'd7 : e.cnt[2:0];
        check("stall_front", e.tag, 32'(stall_front), 32'(e.sf));
        check("bubble",      e.tag, 32'(bubble),      32'(e.bub));
        check("freeze",      e.tag, 32'(freeze),      32'(e.frz));
        check("fwd_sel",     e.tag, 32'(fwd_sel),     32'(e.sel));
        check("stall_cnt",   e.tag, 32'(stall_cnt),   32'(e.cnt));
        check("stall_cnt3",  e.tag, 32'(s_stall_cnt), 32'(cnt3));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0);

    //   fe s0 s1 vld    exd wb ld memd mwb busy fl      sf bub frz sel      cnt
    step(); drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 4'b0000, 0);   // reset
    step(); rst_n = 1'b1;
            drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 4'b0000, 0);
    // EX forward on src0, MEM forward on src1
    step(); drv(1, 5, 7, 2'b11, 5, 1, 0, 7, 1, 0, 0); expect_out(0, 0, 0, 4'b0000, 0);
    // stall-only mode: EX match
    step(); drv(0, 3, 0, 2'b01, 3, 1, 0, 0, 0, 0, 0); expect_out(1, 1, 0, 4'b1001, 0);
    // stall-only mode: MEM match on src1
    step(); drv(0, 0, 6, 2'b10, 0, 0, 0, 6, 1, 0, 0); expect_out(1, 1, 0, 4'b0000, 1);
    // invalid source never matches
    step(); drv(0, 4, 0, 2'b00, 4, 1, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 4'b0000, 2);
    // equal sources both hit EX and MEM: EX wins for each
    step(); drv(1, 9, 9, 2'b11, 9, 1, 0, 9, 1, 0, 0); expect_out(0, 0, 0, 4'b0000, 2);
    // load-use on src1
    step(); drv(1, 0, 2, 2'b10, 2, 1, 1, 0, 0, 0, 0); expect_out(1, 1, 0, 4'b0101, 2);
    // load now in MEM: src1 forwards from WB
    step(); drv(1, 0, 2, 2'b10, 0, 0, 0, 2, 1, 0, 0); expect_out(0, 0, 0, 4'b0000, 3);
    // load in EX without write-back enable: no hazard
    step(); drv(1, 1, 0, 2'b01, 1, 0, 1, 0, 0, 0, 0); expect_out(0, 0, 0, 4'b1000, 3);
    step(); drv(1, 5, 0, 2'b01, 5, 1, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 4'b0000, 3);
    // memory busy for three cycles plus one settle cycle; fwd_sel held
    step(); drv(1, 0, 8, 2'b10, 8, 1, 0, 0, 0, 1, 0); expect_out(1, 0, 1, 4'b0001, 3);
    step(); drv(1, 0, 8, 2'b10, 8, 1, 0, 0, 0, 1, 0); expect_out(1, 0, 1, 4'b0001, 4);
    step(); drv(1, 0, 8, 2'b10, 8, 1, 0, 0, 0, 1, 0); expect_out(1, 0, 1, 4'b0001, 5);
    step(); drv(1, 0, 8, 2'b10, 8, 1, 0, 0, 0, 0, 0); expect_out(1, 0, 1, 4'b0001, 6);
    step(); drv(1, 0, 8, 2'b10, 8, 1, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 4'b0001, 7);
    // flush over a pending load-use
    step(); drv(1, 3, 0, 2'b01, 3, 1, 1, 0, 0, 0, 1); expect_out(0, 0, 0, 4'b0100, 7);
    // flush with memory busy: freeze wins
    step(); drv(1, 3, 0, 2'b01, 3, 1, 1, 0, 0, 1, 1); expect_out(1, 0, 1, 4'b0000, 7);
    step(); drv(1, 3, 0, 2'b01, 3, 1, 1, 0, 0, 0, 1); expect_out(1, 0, 1, 4'b0000, 8);
    step(); drv(1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 4'b0000, 9);
    // narrow counter stays saturated
    step(); drv(0, 3, 0, 2'b01, 3, 1, 0, 0, 0, 0, 0); expect_out(1, 1, 0, 4'b0000, 9);
    step(); drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1, 0); expect_out(1, 0, 1, 4'b0000, 10);
    // reset while in MEM_WAIT
    step(); rst_n = 1'b0;
            drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); expect_out(1, 0, 1, 4'b0000, 11);
    step(); rst_n = 1'b1;
            drv(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0); expect_out(0, 0, 0, 4'b0000, 0);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #1;
    check("scoreboard_drained", 0, 32'(n_pop), 32'(n_push));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
